// File: rtl/qtree_stream_loader.sv
// Post-order tree stream to heap loader with a pointer stack and root batching.
// Define QTREE_LOADER_ERRCHK_EN to enable overflow/underflow/malformed-tree trapping.
module qtree_stream_loader #(
   parameter  int DATA_W      = 67,
   parameter  int PTR_W       = 16,
   parameter  int ARITY       = 4,
   parameter  int STACK_DEPTH = 256,
   parameter  int NUM_TREES   = 2,
   localparam int PL_W        = DATA_W - 2,
   localparam int CH_W        = ARITY * PTR_W,
   localparam int WR_W        = 2 + ((PL_W > CH_W) ? PL_W : CH_W)
) (
   input  logic                       clk,
   input  logic                       aresetn,
   input  logic [DATA_W-1:0]          s_tdata,
   input  logic                       s_tlast,
   input  logic                       s_tvalid,
   output logic                       s_tready,
   output logic [WR_W-1:0]            wr_data,
   output logic                       wr_valid,
   input  logic                       wr_ready,
   input  logic [PTR_W-1:0]           ptr_data,
   input  logic                       ptr_valid,
   output logic [NUM_TREES*PTR_W-1:0] roots_data,
   output logic                       roots_valid,
   input  logic                       roots_ready,
   output logic                       busy,
   output logic                       err
);

   localparam int AW = $clog2(STACK_DEPTH);
   localparam int SW = AW + 1;
   localparam int TW = $clog2(NUM_TREES + 1);

   localparam logic [1:0] TAG_NODE = 2'd2;

   localparam logic [2:0] IDLE     = 3'd0;
   localparam logic [2:0] WRITE    = 3'd1;
   localparam logic [2:0] WAIT_PTR = 3'd2;
   localparam logic [2:0] DONE     = 3'd3;
`ifdef QTREE_LOADER_ERRCHK_EN
   localparam logic [2:0] ERROR    = 3'd4;
`endif

   logic [2:0]                 state_q, state_d;
   logic [SW-1:0]              sp_q, sp_d;
   logic [TW-1:0]              tidx_q, tidx_d;
   logic                       last_q, last_d;
   logic [WR_W-1:0]            rec_q, rec_d;
   logic [NUM_TREES*PTR_W-1:0] roots_q, roots_d;
   logic                       tready_q, wvalid_q, rvalid_q, busy_q;
   logic [PTR_W-1:0]           stack_q [STACK_DEPTH];
   logic                       push;
   logic [WR_W-1:0]            leaf_rec, node_rec;

   always_comb begin
      leaf_rec = '0;
      leaf_rec[DATA_W-1:0] = s_tdata;
   end

   // Children come from the top ARITY entries, oldest in the lowest field.
   always_comb begin
      node_rec = '0;
      node_rec[1:0] = TAG_NODE;
      for (int i = 0; i < ARITY; i++) begin
         node_rec[2+i*PTR_W +: PTR_W] =
            stack_q[sp_q[AW-1:0] - AW'(ARITY) + AW'(i)];
      end
   end

   always_comb begin
      state_d = state_q;
      sp_d    = sp_q;
      tidx_d  = tidx_q;
      last_d  = last_q;
      rec_d   = rec_q;
      roots_d = roots_q;
      push    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (s_tvalid && tready_q) begin
               last_d = s_tlast;
               if (s_tdata[1:0] == TAG_NODE) begin
`ifdef QTREE_LOADER_ERRCHK_EN
                  if (sp_q < SW'(ARITY)) begin
                     state_d = ERROR;
                  end else begin
                     rec_d   = node_rec;
                     sp_d    = sp_q - SW'(ARITY);
                     state_d = WRITE;
                  end
`else
                  rec_d   = node_rec;
                  sp_d    = sp_q - SW'(ARITY);
                  state_d = WRITE;
`endif
               end else begin
                  rec_d   = leaf_rec;
                  state_d = WRITE;
               end
            end
         end
         WRITE: begin
            if (wr_ready) state_d = WAIT_PTR;
         end
         WAIT_PTR: begin
            if (ptr_valid) begin
`ifdef QTREE_LOADER_ERRCHK_EN
               if (sp_q == SW'(STACK_DEPTH)) begin
                  state_d = ERROR;
               end else if (last_q && sp_q != '0) begin
                  state_d = ERROR;
               end else
`endif
               if (!last_q) begin
                  push    = 1'b1;
                  sp_d    = sp_q + SW'(1);
                  state_d = IDLE;
               end else begin
                  // Push and root pop cancel: the root is the returned pointer.
                  for (int i = 0; i < NUM_TREES; i++) begin
                     if (tidx_q == TW'(i)) roots_d[i*PTR_W +: PTR_W] = ptr_data;
                  end
                  tidx_d  = tidx_q + TW'(1);
                  state_d = (tidx_q == TW'(NUM_TREES - 1)) ? DONE : IDLE;
               end
            end
         end
         DONE: begin
            if (roots_ready) begin
               tidx_d  = '0;
               state_d = IDLE;
            end
         end
`ifdef QTREE_LOADER_ERRCHK_EN
         ERROR: begin
            state_d = ERROR;
         end
`endif
         default: state_d = IDLE;
      endcase
`ifndef QTREE_LOADER_ERRCHK_EN
      sp_d[SW-1] = 1'b0;
`endif
   end

   always_ff @(posedge clk) begin
      if (push) stack_q[sp_q[AW-1:0]] <= ptr_data;
   end

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         state_q  <= IDLE;
         sp_q     <= '0;
         tidx_q   <= '0;
         last_q   <= 1'b0;
         rec_q    <= '0;
         roots_q  <= '0;
         tready_q <= 1'b0;
         wvalid_q <= 1'b0;
         rvalid_q <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         sp_q     <= sp_d;
         tidx_q   <= tidx_d;
         last_q   <= last_d;
         rec_q    <= rec_d;
         roots_q  <= roots_d;
         tready_q <= (state_d == IDLE);
         wvalid_q <= (state_d == WRITE);
         rvalid_q <= (state_d == DONE);
         busy_q   <= !(state_d == IDLE && sp_d == '0 && tidx_d == '0);
      end
   end

`ifdef QTREE_LOADER_ERRCHK_EN
   logic err_q;

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) err_q <= 1'b0;
      else          err_q <= (state_d == ERROR);
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   assign s_tready    = tready_q;
   assign wr_valid    = wvalid_q;
   assign wr_data     = rec_q;
   assign roots_valid = rvalid_q;
   assign roots_data  = roots_q;
   assign busy        = busy_q;

endmodule
